// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin (with burst lock) arbitration of NUM_REQ requesters onto one registered 32-bit barrel shifter
module shift_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [5*NUM_REQ-1:0]   req_amount,
  input  logic [2*NUM_REQ-1:0]   req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {IDLE, OUT, STALL} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, lock_owner, rr_sel, gnt_id, idx;
  logic lock_on, lock_hit, rr_any, can_accept, acc, relock;
  logic [CW-1:0] lock_cnt, cnt_base;
  logic [31:0] data_a [NUM_REQ];
  logic [4:0] amt_a [NUM_REQ];
  logic [1:0] mode_a [NUM_REQ];
  logic [31:0] op, shifted;
  logic signed [31:0] sra;
  logic [4:0] amt;
  logic [1:0] mode;
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_a[g] = req_data[32*g +: 32];
      assign amt_a[g]  = req_amount[5*g +: 5];
      assign mode_a[g] = req_mode[2*g +: 2];
    end
  endgenerate
  assign rsp_valid  = state != IDLE;
  assign busy       = rsp_valid | (|req_valid);
  assign can_accept = !rsp_valid || rsp_ready;
  assign lock_hit   = lock_on && req_valid[lock_owner] && lock_cnt < CW'(LOCK_MAX);
  // Lowest offset from rr_ptr wins, so scan from the far end down.
  always_comb begin
    rr_sel = '0;
    rr_any = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        rr_sel = idx;
        rr_any = 1'b1;
      end
    end
  end
  assign gnt_id    = lock_hit ? lock_owner : rr_sel;
  assign acc       = (lock_hit || rr_any) && can_accept;
  assign req_ready = acc ? (NUM_REQ'(1) << gnt_id) : '0;
  assign op        = data_a[gnt_id];
  assign amt       = amt_a[gnt_id];
  assign mode      = mode_a[gnt_id];
  assign sra       = $signed(op) >>> amt;
  assign shifted   = mode == 2'b00 ? op >> amt : mode == 2'b01 ? op << amt : mode == 2'b10 ? sra : op;
  assign cnt_base  = (lock_on && lock_owner == gnt_id) ? lock_cnt : '0;
  assign relock    = req_lock[gnt_id] && cnt_base < CW'(LOCK_MAX - 1);
  always_comb begin
    state_nx = acc ? OUT : (state == IDLE || rsp_ready) ? IDLE : STALL;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
      rr_ptr     <= '0;
      lock_on    <= 1'b0;
      lock_owner <= '0;
      lock_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        rsp_data   <= shifted;
        rsp_id     <= gnt_id;
        rsp_err    <= &mode;
        rr_ptr     <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        lock_on    <= relock;
        lock_owner <= gnt_id;
        lock_cnt   <= relock ? cnt_base + 1'b1 : '0;
      end else if (lock_on && !req_valid[lock_owner]) begin
        lock_on  <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter (arbitration order, lock, stall, pass-through, reset)
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_valid = '0, req_lock = '0, req_ready;
  logic [127:0] req_data = '0;
  logic [19:0] req_amount = '0;
  logic [7:0] req_mode = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [1:0] rsp_id;
  typedef struct packed {logic [1:0] id; logic [31:0] d; logic e;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_cmp = 0, n_err = 0;

  shift_arbiter #(.NUM_REQ(4), .ID_W(2), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_data(req_data), .req_amount(req_amount),
    .req_mode(req_mode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] shf(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(d) >>> a;
    case (m)
      2'b00: return d >> a;
      2'b01: return d << a;
      2'b10: return s;
      default: return d;
    endcase
  endfunction

  function automatic exp_t mk(input int i);
    exp_t r;
    r.id = 2'(i);
    r.d  = shf(req_data[32*i +: 32], req_amount[5*i +: 5], req_mode[2*i +: 2]);
    r.e  = req_mode[2*i +: 2] == 2'b11;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
    req_data[32*i +: 32] = d;
    req_amount[5*i +: 5] = a;
    req_mode[2*i +: 2]   = m;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_lock = '0; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err, req_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%h id=%0d err=%b rdy=%b busy=%b, want all zero", rsp_valid, rsp_data, rsp_id, rsp_err, req_ready, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] modes [2] = '{2'b10, 2'b01};
    logic [31:0] want [2] = '{32'hC000_0000, 32'h0000_0002};
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front(); n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
          n_err++;
          $display("FAIL single rsp %0d: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", k, rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
        end
      end
      if (k < 2) begin
        set_req(0, 32'h8000_0001, 5'd1, modes[k]);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single ready %0d: got %b want 0001", k, req_ready); end
        e = {2'd0, want[k], 1'b0};
        exp_q.push_back(e);
      end else req_valid = '0;
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single idle: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int ids [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1111_1111 * (i + 1), 5'(i), 2'b00);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front(); n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
          n_err++;
          $display("FAIL rr rsp %0d: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", k, rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
        end
      end
      if (k < 5) begin
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'(1 << ids[k])) begin n_err++; $display("FAIL rr grant %0d: got %b want id %0d", k, req_ready, ids[k]); end
        exp_q.push_back(mk(ids[k]));
      end else req_valid = '0;
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr drain: got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_lock();
    int ids [14] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3, 0, 1, 2};
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, 32'h0F00_00F1 + i, 5'(i + 1), 2'b01);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front(); n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
          n_err++;
          $display("FAIL lock rsp %0d: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", k, rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
        end
      end
      if (k < 14) begin
        req_valid = 4'b1111; req_lock = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'(1 << ids[k])) begin n_err++; $display("FAIL lock grant %0d: got %b want id %0d", k, req_ready, ids[k]); end
        exp_q.push_back(mk(ids[k]));
      end else begin req_valid = '0; req_lock = '0; end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    set_req(1, 32'hF0F0_1234, 5'd4, 2'b00);
    set_req(3, 32'hA5A5_0001, 5'd3, 2'b01);
    @(negedge clk);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL stall first grant: got %b want 0010", req_ready); end
    exp_q.push_back(mk(1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 4'b1010;
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall ready %0d: got %b want 0000", c, req_ready); end
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, exp_q[0]}) begin
        n_err++;
        $display("FAIL stall hold %0d: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, rsp_err, exp_q[0].id, exp_q[0].d);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL stall drain rsp: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
    end
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL stall drain grant: got %b want 1000", req_ready); end
    exp_q.push_back(mk(3));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL stall next rsp: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
    end
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall idle: got v=%b want 0", rsp_valid); end
  endtask

  task automatic test_passthrough();
    logic [31:0] din [4] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [4:0] amts [4] = '{5'd7, 5'd0, 5'd0, 5'd0};
    logic [1:0] modes [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front(); n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
          n_err++;
          $display("FAIL pass rsp %0d: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", k, rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
        end
      end
      if (k < 4) begin
        set_req(3, din[k], amts[k], modes[k]);
        req_valid = 4'b1000;
        e = {2'd3, din[k], k == 0};
        exp_q.push_back(e);
      end else req_valid = '0;
    end
  endtask

  task automatic test_reset_stall();
    reset_dut();
    set_req(2, 32'h5555_AAAA, 5'd2, 2'b00);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rststall grant: got %b want 0100", req_ready); end
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rststall stalled: got v=%b want 1", rsp_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rststall flush: got v=%b want 0", rsp_valid); end
    for (int i = 0; i < 4; i++) set_req(i, 32'hC001_0000 + i, 5'd8, 2'b10);
    rsp_ready = 1'b1; req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rststall rr restart: got %b want 0001", req_ready); end
    exp_q.push_back(mk(0));
    @(negedge clk);
    e = exp_q.pop_front(); n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL rststall rsp: got v=%b id=%0d d=%h err=%b, want id=%0d d=%h err=%b", rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.d, e.e);
    end
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rststall stale %0d: got v=%b want 0", c, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_stall();
    test_passthrough();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
